// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// start/done handshake, RISC-V divide-by-zero and overflow results, and flush abort.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0]  MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   bmag_q, bmag_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode on the raw inputs, used only when a start is accepted
  logic            a_signed, b_signed, a_neg, b_neg, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // Remainder takes the dividend's sign; everything else takes the XOR
    neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MinNeg) && (b == '1);
  end

  // Datapath step and final sign fix on the registered state
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, bmag_q};
    prod      = {acc_q, lo_q};
    prod_s    = neg_q ? -prod : prod;
    quot_s    = neg_q ? -lo_q : lo_q;
    rem_s     = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    bmag_d   = bmag_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d   = op;
          neg_d  = neg_in;
          bmag_d = b_mag;
          lo_d   = a_mag;
          acc_d  = '0;
          cnt_d  = '0;
          if (div_zero) begin
            result_d = op[1] ? a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : a;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == LastCnt) begin
          unique case (op_q)
            3'b000:                 result_d = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quot_s;
            default:                result_d = rem_s;
          endcase
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!op_q[2]) begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      bmag_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): results, latency, fast paths,
// flush abort, async reset mid-operation and start-while-busy.
module tb_muldiv_unit;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  localparam int NormLat = 33;
  localparam int FastLat = 0;

  logic        clk, rst_n, start, flush, ready, done;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int n_total = 0;
  int n_bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Edges counted after the current sample point until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_val({tag, "_res"}, result, exp);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check_val({tag, "_rdy"}, {30'd0, ready, done}, 32'd2);
  endtask

  initial begin
    int lat;
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #12;
    check_val("reset", {ready, done, result[29:0]}, 32'h8000_0000);
    rst_n = 1'b1;

    run_op("mul_neg",  OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NormLat);
    run_op("mul_pos",  OpMul,    32'h1234_5678,  32'h10,        32'h2345_6780, NormLat);
    run_op("mulh_min", OpMulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, NormLat);
    run_op("mulhu",    OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NormLat);
    run_op("mulhsu",   OpMulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, NormLat);
    run_op("div_neg",  OpDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, NormLat);
    run_op("rem_neg",  OpRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, NormLat);
    run_op("divu",     OpDivu,   32'd100,        32'd7,         32'd14,        NormLat);
    run_op("remu",     OpRemu,   32'd100,        32'd7,         32'd2,         NormLat);
    run_op("rem_negb", OpRem,    32'd7,          32'hFFFF_FFFE, 32'd1,         NormLat);
    run_op("divu_sml", OpDivu,   32'd3,          32'd7,         32'd0,         NormLat);
    run_op("div_z",    OpDiv,    32'd5,          32'd0,         32'hFFFF_FFFF, FastLat);
    run_op("remu_z",   OpRemu,   32'd5,          32'd0,         32'd5,         FastLat);
    run_op("divu_z",   OpDivu,   32'd5,          32'd0,         32'hFFFF_FFFF, FastLat);
    run_op("div_ovf",  OpDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, FastLat);
    run_op("rem_ovf",  OpRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         FastLat);

    // Flush at edge 10 of a multiply
    @(negedge clk);
    start = 1'b1;
    op    = OpMul;
    a     = 32'd6;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("busy_rdy", {31'd0, ready}, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_val("flush_rdy", {30'd0, ready, done}, 32'd2);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_val("flush_nodone", 32'(pulses), 32'd0);
    check_val("flush_res", result, 32'd0);
    run_op("divu_aft", OpDivu, 32'd9, 32'd3, 32'd3, NormLat);

    // Async reset mid-calculation
    @(negedge clk);
    start = 1'b1;
    op    = OpMulhu;
    a     = 32'hFFFF_FFFF;
    b     = 32'h2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_ctl", {30'd0, ready, done}, 32'd2);
    check_val("arst_res", result, 32'd0);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_val("arst_nodone", 32'(pulses), 32'd0);

    // Start held while busy with different operands
    @(negedge clk);
    start = 1'b1;
    op    = OpDivu;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    op = OpMul;
    a  = 32'd3;
    b  = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    check_val("busy2_rdy", {31'd0, ready}, 32'd0);
    wait_done(lat);
    check_val("busy2_res", result, 32'd14);
    check_val("busy2_lat", 32'(lat), 32'(NormLat - 10));
    @(posedge clk);
    #1;
    check_val("busy2_idle", {30'd0, ready, done}, 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
